// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit order and every glyph pattern
// used by the multiplexed display driver.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // Bit position of each segment inside a seg_t (a is the MSB).
  typedef enum int {
    SEG_G = 0,
    SEG_F = 1,
    SEG_E = 2,
    SEG_D = 3,
    SEG_C = 4,
    SEG_B = 5,
    SEG_A = 6
  } seg_bit_e;

  localparam seg_t PAT_0     = 7'b1111110;
  localparam seg_t PAT_1     = 7'b0110000;
  localparam seg_t PAT_2     = 7'b1101101;
  localparam seg_t PAT_3     = 7'b1111001;
  localparam seg_t PAT_4     = 7'b0110011;
  localparam seg_t PAT_5     = 7'b1011011;
  localparam seg_t PAT_6     = 7'b1011111;
  localparam seg_t PAT_7     = 7'b1110000;
  localparam seg_t PAT_8     = 7'b1111111;
  localparam seg_t PAT_9     = 7'b1111011;
  localparam seg_t PAT_HEX_A = 7'b1110111;
  localparam seg_t PAT_HEX_B = 7'b0011111;
  localparam seg_t PAT_HEX_C = 7'b1001110;
  localparam seg_t PAT_HEX_D = 7'b0111101;
  localparam seg_t PAT_HEX_E = 7'b1001111;
  localparam seg_t PAT_HEX_F = 7'b1000111;

  localparam seg_t PAT_BLANK = 7'b0000000;
  localparam seg_t PAT_DASH  = 7'b0000001;

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble-to-glyph decoder; values above 9 show as hex letters or
// a dash depending on hex_en.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = PAT_BLANK;
    case (nibble)
      4'h0: pattern = PAT_0;
      4'h1: pattern = PAT_1;
      4'h2: pattern = PAT_2;
      4'h3: pattern = PAT_3;
      4'h4: pattern = PAT_4;
      4'h5: pattern = PAT_5;
      4'h6: pattern = PAT_6;
      4'h7: pattern = PAT_7;
      4'h8: pattern = PAT_8;
      4'h9: pattern = PAT_9;
      4'hA: pattern = hex_en ? PAT_HEX_A : PAT_DASH;
      4'hB: pattern = hex_en ? PAT_HEX_B : PAT_DASH;
      4'hC: pattern = hex_en ? PAT_HEX_C : PAT_DASH;
      4'hD: pattern = hex_en ? PAT_HEX_D : PAT_DASH;
      4'hE: pattern = hex_en ? PAT_HEX_E : PAT_DASH;
      4'hF: pattern = hex_en ? PAT_HEX_F : PAT_DASH;
      default: pattern = PAT_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed seven-segment driver with a tear-free load handshake:
// new data is staged in a pending register and only shown from a frame boundary.
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    hex_en,
  input  logic                    blank_lz,
  output logic                    ready,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W  = 4 * NUM_DIGITS;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]    presc, presc_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic                  slot_end, frame_end;

  logic [DATA_W-1:0]     display, display_next;
  logic [DATA_W-1:0]     pending;
  logic                  pending_valid;
  logic                  ready_q;
  logic                  accept, transfer;

  logic [IDX_W-1:0]      msd;
  logic                  blank;
  logic [3:0]            nibble;
  logic [6:0]            pattern;
  logic [6:0]            seg_next, seg_q;
  logic [NUM_DIGITS-1:0] dig_next, dig_q;

  always_comb begin
    slot_end   = (presc == PRESC_LAST);
    frame_end  = slot_end && (idx == IDX_LAST);
    presc_next = slot_end ? '0 : presc + 1'b1;
    idx_next   = idx;
    if (slot_end) begin
      idx_next = frame_end ? '0 : idx + 1'b1;
    end
  end

  // A load and a transfer can never coincide: accepting needs ready, which
  // implies nothing is pending, so a load on a boundary edge waits a frame.
  always_comb begin
    accept       = load && ready_q;
    transfer     = frame_end && pending_valid;
    display_next = transfer ? pending : display;
  end

  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (display_next[4*i +: 4] != 4'h0) begin
        msd = IDX_W'(i);
      end
    end
  end

  // Output registers are loaded from next-state values so the pattern and the
  // enables line up with the slot that starts on this edge.
  always_comb begin
    nibble   = display_next[{idx_next, 2'b00} +: 4];
    blank    = blank_lz && (idx_next > msd);
    seg_next = blank ? PAT_BLANK : pattern;
    dig_next = '0;
    if (presc_next != '0) begin
      dig_next = NUM_DIGITS'(1) << idx_next;
    end
  end

  seg_decoder u_decoder (
    .nibble  (nibble),
    .hex_en  (hex_en),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc_next;
      idx   <= idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      display <= display_next;
      if (transfer) begin
        pending_valid <= 1'b0;
        ready_q       <= 1'b1;
      end
      if (accept) begin
        pending       <= data_in;
        pending_valid <= 1'b1;
        ready_q       <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= PAT_BLANK;
      dig_q <= '0;
    end else begin
      seg_q <= seg_next;
      dig_q <= dig_next;
    end
  end

  assign ready    = ready_q;
  assign seg_out  = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign digit_en = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Bench for seg_mux_driver (4 digits, 4 cycles per slot): directed scenarios
// followed by random traffic, all checked against a frame-arithmetic model.
module tb_seg_mux_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] DEC_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] data_in  = '0;
  logic        hex_en   = 1'b0;
  logic        blank_lz = 1'b0;
  logic        ready;
  logic [6:0]  seg_out;
  logic [3:0]  digit_en;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model state: cycle count since reset release, shown value, staged value.
  int          m_c;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pv;

  always #5 clk = ~clk;

  seg_mux_driver #(
    .NUM_DIGITS     (N),
    .DIV            (DIV),
    .SEG_ACTIVE_LOW (0),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data_in  (data_in),
    .hex_en   (hex_en),
    .blank_lz (blank_lz),
    .ready    (ready),
    .seg_out  (seg_out),
    .digit_en (digit_en)
  );

  function automatic logic [6:0] expect_seg(int idx, logic [15:0] disp, bit hx, bit bz);
    logic [15:0] upper;
    int nib;
    upper = disp >> (4 * idx);
    nib   = int'(upper[3:0]);
    if (bz && idx > 0 && upper == 16'h0) return 7'b0000000;
    if (nib >= 10 && !hx) return 7'b0000001;
    return DEC_TABLE[nib];
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, m_c);
    end
  endtask

  task automatic applyStimulus(input bit ld, input logic [15:0] d, input bit hx, input bit bz);
    bit acc, xfer;
    int idx, ph;
    logic [3:0] exp_dig;
    load     = ld;
    data_in  = d;
    hex_en   = hx;
    blank_lz = bz;
    @(posedge clk);
    acc  = ld && !m_pv;
    xfer = ((m_c % FRAME) == FRAME - 1) && m_pv;
    if (xfer) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end
    if (acc) begin
      m_pend = d;
      m_pv   = 1'b1;
    end
    m_c++;
    @(negedge clk);
    idx     = (m_c / DIV) % N;
    ph      = m_c % DIV;
    exp_dig = (ph == 0) ? 4'b1111 : ~(4'b0001 << idx);
    checkOutput("ready", 16'(ready), 16'(!m_pv));
    checkOutput("digit_en", 16'(digit_en), 16'(exp_dig));
    checkOutput($sformatf("seg_out[d%0d]", idx), 16'(seg_out), 16'(expect_seg(idx, m_disp, hx, bz)));
  endtask

  task automatic idle(input int n, input bit hx, input bit bz);
    repeat (n) applyStimulus(1'b0, 16'h0, hx, bz);
  endtask

  // Reset lands between edges so the outputs must react with no clock.
  task automatic doReset();
    @(negedge clk);
    #2;
    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_digit_en", 16'(digit_en), 16'h000F);
    checkOutput("rst_seg_out", 16'(seg_out), 16'h0000);
    checkOutput("rst_ready", 16'(ready), 16'h0001);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_c    = 0;
    m_disp = '0;
    m_pend = '0;
    m_pv   = 1'b0;
  endtask

  initial begin
    int lat;
    int guard;

    $display("[TB] seg_mux_driver bench start");
    doReset();
    idle(6, 1'b1, 1'b0);

    // Scan a plain decimal value.
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
    idle(2 * FRAME, 1'b1, 1'b0);

    // Hex letters, then the same value with hex decoding off.
    applyStimulus(1'b1, 16'h00AF, 1'b1, 1'b0);
    idle(2 * FRAME, 1'b1, 1'b0);
    idle(FRAME, 1'b0, 1'b0);

    // Leading-zero blanking, including the all-zero value.
    applyStimulus(1'b1, 16'h0050, 1'b1, 1'b1);
    idle(2 * FRAME, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1);
    idle(2 * FRAME, 1'b1, 1'b1);

    // A second load while busy must be dropped.
    applyStimulus(1'b1, 16'h1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b1, 1'b0);
    idle(2 * FRAME, 1'b1, 1'b0);

    // Load exactly on a frame-boundary edge.
    guard = 0;
    while (((m_c % FRAME) != FRAME - 1) && guard < FRAME) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      guard++;
    end
    applyStimulus(1'b1, 16'h4321, 1'b1, 1'b0);
    lat = 1;
    while (ready !== 1'b1 && lat < 40) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      lat++;
    end
    checkOutput("boundary_latency", 16'(lat), 16'd17);
    idle(FRAME, 1'b1, 1'b0);

    // Reset mid-frame with data pending: it must never appear.
    applyStimulus(1'b1, 16'h9999, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);
    doReset();
    idle(2 * FRAME + 3, 1'b1, 1'b0);

    // Random traffic.
    repeat (400) begin
      applyStimulus(($urandom_range(0, 7) == 0), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
